// File: rtl/refill_read_arbiter.sv
// Shared memory read-port arbiter for ICache, DCache and D-uncache refills.
// Grants one requester at a time with fixed priority (D-uncache > DCache >
// ICache). A starvation counter forces an ICache grant after a long stream of
// data misses. The response is steered back to whichever requester was granted.
module refill_read_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ren_i,
  input  logic [ADDR_W-1:0] inst_araddr_i,
  input  logic              inst_uncached_i,
  output logic              inst_rvalid_o,
  output logic [LINE_W-1:0] inst_rdata_o,
  input  logic              data_ren_i,
  input  logic [ADDR_W-1:0] data_araddr_i,
  output logic              data_rvalid_o,
  output logic [LINE_W-1:0] data_rdata_o,
  input  logic              ducache_ren_i,
  input  logic [ADDR_W-1:0] ducache_araddr_i,
  output logic              ducache_rvalid_o,
  output logic [WORD_W-1:0] ducache_rdata_o,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_araddr_o,
  output logic              mem_uncached_o,
  input  logic              mem_rvalid_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  // Byte-offset bits inside one cache line (5 for a 256-bit line).
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA, OWN_DUC} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, win;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] win_addr;
  logic              win_unc;
  logic              resp;

  // Cached refills always fetch the whole line, so drop the offset bits.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // Winner selection in IDLE plus the address/burst type it would issue.
  always_comb begin
    win      = OWN_NONE;
    win_addr = '0;
    win_unc  = 1'b0;
    if (state == IDLE) begin
      if (inst_ren_i && starve_cnt == LIMIT) win = OWN_INST;
      else if (ducache_ren_i)                win = OWN_DUC;
      else if (data_ren_i)                   win = OWN_DATA;
      else if (inst_ren_i)                   win = OWN_INST;
    end
    case (win)
      OWN_INST: begin
        win_addr = inst_uncached_i ? inst_araddr_i : line_align(inst_araddr_i);
        win_unc  = inst_uncached_i;
      end
      OWN_DATA: win_addr = line_align(data_araddr_i);
      OWN_DUC: begin
        win_addr = ducache_araddr_i;
        win_unc  = 1'b1;
      end
      default: ;
    endcase
  end

  // A completion only counts while a request is outstanding.
  assign resp   = (state == WAIT) && mem_rvalid_i;
  assign busy_o = (state != IDLE);

  // Next-state logic: one grant cycle, WAIT for memory, one RESP gap cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win != OWN_NONE) state_nxt = WAIT;
      WAIT:    if (mem_rvalid_i)    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and owner registers; owner persists until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nxt;
      if (win != OWN_NONE) owner <= win;
    end
  end

  // Downstream request: latched on grant, held through WAIT, dropped on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ren_o      <= 1'b0;
      mem_araddr_o   <= '0;
      mem_uncached_o <= 1'b0;
    end else if (win != OWN_NONE) begin
      mem_ren_o      <= 1'b1;
      mem_araddr_o   <= win_addr;
      mem_uncached_o <= win_unc;
    end else if (resp) begin
      mem_ren_o      <= 1'b0;
    end
  end

  // Steer the returned data and a one-cycle valid pulse to the owner only.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rvalid_o    <= 1'b0;
      data_rvalid_o    <= 1'b0;
      ducache_rvalid_o <= 1'b0;
      inst_rdata_o     <= '0;
      data_rdata_o     <= '0;
      ducache_rdata_o  <= '0;
    end else begin
      inst_rvalid_o    <= resp && (owner == OWN_INST);
      data_rvalid_o    <= resp && (owner == OWN_DATA);
      ducache_rvalid_o <= resp && (owner == OWN_DUC);
      if (resp && owner == OWN_INST) inst_rdata_o    <= mem_rdata_i;
      if (resp && owner == OWN_DATA) data_rdata_o    <= mem_rdata_i;
      if (resp && owner == OWN_DUC)  ducache_rdata_o <= mem_rdata_i[WORD_W-1:0];
    end
  end

  // ICache starvation counter: counts cycles ICache waits, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!inst_ren_i || win == OWN_INST) begin
      starve_cnt <= '0;
    end else if (owner != OWN_INST && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
